pipe_stage_skid: RTL

Parametrised, handshaked successor to the fixed-field stage registers between pipeline stages such as ID/EX. It carries an opaque data payload and a control bundle with valid/ready flow control, a 2-entry skid buffer (full throughput, registered ready), synchronous flush and bubble semantics. A bubble forces the control bundle to zero, so RegWrite, MemWrite and similar signals read as NOP downstream. One instance per pipeline boundary; the stage-specific field packing lives outside this block.

---
 rtl/pipe_pkg.sv | 17 +
 rtl/pipe_skid_entry.sv | 42 ++++
 rtl/pipe_stage_skid.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types and defaults for the handshaked pipeline stage register.
package pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CTRL_W_DEF = 16;
  localparam int CNT_W_DEF  = 16;

  // Encoding doubles as the occupancy value.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [CTRL_W_DEF-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/pipe_skid_entry.sv
// One holding slot of the stage: valid flag plus payload and control bundle.
module pipe_skid_entry #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [CTRL_W-1:0] r_ctrl;

  // Clear wins over load so a flush always leaves a zeroed slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ctrl  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ctrl  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_ctrl  <= i_ctrl;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_ctrl  = r_ctrl;

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage register with 2-entry skid buffer, flush and bubble zeroing.
// Optional stall statistics counter compiled in with `define PIPE_STATS_EN.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  state_t r_state;
  state_t w_state_next;
  logic   r_rst_done;

  logic              w_in_fire, w_out_fire;
  logic              w_main_load, w_main_clear, w_main_from_skid;
  logic              w_skid_load, w_skid_clear;
  logic              w_main_valid, w_skid_valid;
  logic [DATA_W-1:0] w_main_data, w_skid_data, w_main_d_data;
  logic [CTRL_W-1:0] w_main_ctrl, w_skid_ctrl, w_main_d_ctrl;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_rst_done <= 1'b0;
    else        r_rst_done <= 1'b1;
  end

  // Skid valid is set exactly in TWO, so ready stays a pure flop decode.
  assign in_ready   = r_rst_done & ~w_skid_valid;
  assign out_valid  = w_main_valid;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  always_comb begin
    w_state_next     = r_state;
    w_main_load      = 1'b0;
    w_main_clear     = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_load      = 1'b0;
    w_skid_clear     = 1'b0;
    if (flush) begin
      w_main_clear = 1'b1;
      w_skid_clear = 1'b1;
      w_state_next = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_fire) begin
            w_main_load  = 1'b1;
            w_state_next = ONE;
          end
        end
        ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_main_load = 1'b1;
          end else if (w_in_fire) begin
            w_skid_load  = 1'b1;
            w_state_next = TWO;
          end else if (w_out_fire) begin
            w_main_clear = 1'b1;
            w_state_next = EMPTY;
          end
        end
        TWO: begin
          if (w_out_fire) begin
            w_main_load      = 1'b1;
            w_main_from_skid = 1'b1;
            w_skid_clear     = 1'b1;
            w_state_next     = ONE;
          end
        end
        default: begin
          w_main_clear = 1'b1;
          w_skid_clear = 1'b1;
          w_state_next = EMPTY;
        end
      endcase
    end
  end

  assign w_main_d_data = w_main_from_skid ? w_skid_data : in_data;
  assign w_main_d_ctrl = w_main_from_skid ? w_skid_ctrl : in_ctrl;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= EMPTY;
    else        r_state <= w_state_next;
  end

  pipe_skid_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_main_load),
    .i_clear (w_main_clear),
    .i_data  (w_main_d_data),
    .i_ctrl  (w_main_d_ctrl),
    .o_valid (w_main_valid),
    .o_data  (w_main_data),
    .o_ctrl  (w_main_ctrl)
  );

  pipe_skid_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_data  (in_data),
    .i_ctrl  (in_ctrl),
    .o_valid (w_skid_valid),
    .o_data  (w_skid_data),
    .o_ctrl  (w_skid_ctrl)
  );

  // Bubble: an empty stage presents NOP control and zero payload.
  assign out_data  = w_main_valid ? w_main_data : '0;
  assign out_ctrl  = w_main_valid ? w_main_ctrl : CTRL_W'(CTRL_NOP);
  assign occupancy = r_state;

`ifdef PIPE_STATS_EN
  logic [CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule
